// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// the channel-tag header nibble and the channel index width helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PASS = 2'd2
  } state_e;

  localparam logic [3:0] HDR_TAG = 4'hA;

  function automatic int chw_f(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// AXIS bundle between NUM_CH byte-stream requesters and the shared UART
// transmit port; the arbiter takes the slave view, its environment the master.
interface uart_tx_arbiter_if #(
  parameter int NUM_CH     = 4,
  parameter int AXIS_WIDTH = 8
);
  localparam int CHW = uart_pkg::chw_f(NUM_CH);

  logic [NUM_CH*AXIS_WIDTH-1:0] s_axis_tdata;
  logic [NUM_CH-1:0]            s_axis_tvalid;
  logic [NUM_CH-1:0]            s_axis_tlast;
  logic [NUM_CH-1:0]            s_axis_tready;
  logic [AXIS_WIDTH-1:0]        m_axis_tdata;
  logic                         m_axis_tvalid;
  logic                         m_axis_tlast;
  logic [CHW-1:0]               m_axis_tid;
  logic                         m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
  );

endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: first asserted request strictly after
// last_i, wrapping modulo NUM_CH; returns one-hot grant and encoded index.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]          req_i,
  input  logic [chw_f(NUM_CH)-1:0]   last_i,
  output logic [NUM_CH-1:0]          gnt_o,
  output logic [chw_f(NUM_CH)-1:0]   idx_o
);

  localparam int CHW = chw_f(NUM_CH);

  logic found;
  int   ch;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    ch    = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      ch = (int'(last_i) + i) % NUM_CH;
      if (!found && req_i[ch]) begin
        found     = 1'b1;
        gnt_o[ch] = 1'b1;
        idx_o     = CHW'(ch);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one registered UART AXIS port
// among NUM_CH requesters, with mid-packet inactivity timeout.
// Optional channel-tag header byte per packet: define UART_ARB_HDR_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int AXIS_WIDTH  = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_tx_arbiter_if.slave            bus,
  output logic [chw_f(NUM_CH)-1:0]    grant_ch,
  output logic                        busy,
  output logic                        timeout_pulse
);

  localparam int CHW  = chw_f(NUM_CH);
  localparam int CNTW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  state_e                state_q, state_d;
  logic [CHW-1:0]        grant_q, grant_d;
  logic [CHW-1:0]        last_q, last_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic                  pulse_q, pulse_d;
  logic [AXIS_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic                  m_tlast_q, m_tlast_d;
  logic [CHW-1:0]        m_tid_q, m_tid_d;

  logic [NUM_CH-1:0]     arb_gnt;
  logic [CHW-1:0]        arb_idx;
  logic [NUM_CH-1:0]     tready;
  logic                  out_ready, g_vld, g_last, load;
  logic [AXIS_WIDTH-1:0] g_data, ld_data;
  logic                  ld_last;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req_i  (bus.s_axis_tvalid),
    .last_i (last_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx)
  );

  assign out_ready = !m_tvalid_q || bus.m_axis_tready;
  assign g_vld     = bus.s_axis_tvalid[grant_q];
  assign g_last    = bus.s_axis_tlast[grant_q];
  assign g_data    = bus.s_axis_tdata[int'(grant_q)*AXIS_WIDTH +: AXIS_WIDTH];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    tready  = '0;
    load    = 1'b0;
    ld_data = '0;
    ld_last = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (|arb_gnt) begin
          grant_d = arb_idx;
`ifdef UART_ARB_HDR_EN
          state_d = ST_HDR;
`else
          state_d = ST_PASS;
`endif
        end
      end
`ifdef UART_ARB_HDR_EN
      ST_HDR: begin
        if (out_ready) begin
          load    = 1'b1;
          ld_data = {HDR_TAG, (AXIS_WIDTH-4)'(grant_q)};
          state_d = ST_PASS;
        end
      end
`endif
      ST_PASS: begin
        tready[grant_q] = out_ready;
        if (g_vld && out_ready) begin
          load    = 1'b1;
          ld_data = g_data;
          ld_last = g_last;
          cnt_d   = '0;
          if (g_last) begin
            last_d  = grant_q;
            state_d = ST_IDLE;
          end
        // Idle requester only counts while the output can move; backpressure freezes it.
        end else if (TIMEOUT_CYC != 0 && !g_vld && out_ready) begin
          if (cnt_q == CNTW'(TIMEOUT_CYC - 1)) begin
            cnt_d   = '0;
            last_d  = grant_q;
            pulse_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = m_tvalid_q;
    m_tlast_d  = m_tlast_q;
    m_tid_d    = m_tid_q;
    if (load) begin
      m_tdata_d  = ld_data;
      m_tvalid_d = 1'b1;
      m_tlast_d  = ld_last;
      m_tid_d    = grant_q;
    end else if (bus.m_axis_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      last_q     <= CHW'(NUM_CH - 1);
      cnt_q      <= '0;
      pulse_q    <= 1'b0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tid_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      pulse_q    <= pulse_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      m_tid_q    <= m_tid_d;
    end
  end

  assign bus.s_axis_tready = tready;
  assign bus.m_axis_tdata  = m_tdata_q;
  assign bus.m_axis_tvalid = m_tvalid_q;
  assign bus.m_axis_tlast  = m_tlast_q;
  assign bus.m_axis_tid    = m_tid_q;
  assign grant_ch          = grant_q;
  assign busy              = (state_q != ST_IDLE);
  assign timeout_pulse     = pulse_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-channel byte queues feed the
// requesters, accepted output beats are captured and compared to hand tables.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NUM_CH      = 4;
  localparam int AXIS_WIDTH  = 8;
  localparam int TIMEOUT_CYC = 16;
  localparam int CHW         = chw_f(NUM_CH);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [CHW-1:0] grant_ch;
  logic           busy;
  logic           timeout_pulse;

  uart_tx_arbiter_if #(.NUM_CH(NUM_CH), .AXIS_WIDTH(AXIS_WIDTH)) bus ();

  uart_tx_arbiter #(
    .NUM_CH(NUM_CH), .AXIS_WIDTH(AXIS_WIDTH), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .grant_ch(grant_ch), .busy(busy), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [8:0]        mem [NUM_CH][32];
  int                rd  [NUM_CH];
  int                wr  [NUM_CH];
  logic [7:0]        o_data [64];
  logic              o_last [64];
  logic [CHW-1:0]    o_tid  [64];
  int                o_cyc  [64];
  int                n_out;
  int                cyc;
  logic [NUM_CH-1:0] acc;

  task automatic drive();
    logic [NUM_CH*AXIS_WIDTH-1:0] d;
    logic [NUM_CH-1:0]            v, l;
    d = bus.s_axis_tdata;
    v = '0;
    l = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd[c] < wr[c]) begin
        v[c] = 1'b1;
        l[c] = mem[c][rd[c]][8];
        d[c*AXIS_WIDTH +: AXIS_WIDTH] = mem[c][rd[c]][7:0];
      end
    end
    bus.s_axis_tdata  = d;
    bus.s_axis_tvalid = v;
    bus.s_axis_tlast  = l;
  endtask

  task automatic push(input int c, input logic [7:0] data, input logic last);
    mem[c][wr[c]] = {last, data};
    wr[c]++;
    drive();
  endtask

  task automatic clear_queues();
    for (int c = 0; c < NUM_CH; c++) begin
      rd[c] = 0;
      wr[c] = 0;
    end
    n_out = 0;
    acc   = '0;
    drive();
  endtask

  // One clock: sample handshakes at the edge, then advance sources 1ns later.
  task automatic step();
    @(posedge clk);
    cyc++;
    acc = bus.s_axis_tvalid & bus.s_axis_tready;
    vectors++;
    if ($countones(bus.s_axis_tready) > 1) begin
      miscompares++;
      $display("FAIL ready_onehot: tready=%b, required at most one bit set", bus.s_axis_tready);
    end
    if (bus.m_axis_tvalid && bus.m_axis_tready && n_out < 64) begin
      o_data[n_out] = bus.m_axis_tdata;
      o_last[n_out] = bus.m_axis_tlast;
      o_tid[n_out]  = bus.m_axis_tid;
      o_cyc[n_out]  = cyc;
      n_out++;
    end
    #1;
    for (int c = 0; c < NUM_CH; c++)
      if (acc[c] && rd[c] < wr[c]) rd[c]++;
    drive();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    clear_queues();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.m_axis_tready = 1'b1;
    clear_queues();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata, bus.m_axis_tid} !== '0) begin
      miscompares++;
      $display("FAIL reset_out: vld/last/data/tid=%b/%b/%h/%0d, required all 0",
               bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata, bus.m_axis_tid);
    end
    vectors++;
    if ({grant_ch, busy, timeout_pulse, bus.s_axis_tready} !== '0) begin
      miscompares++;
      $display("FAIL reset_status: grant=%0d busy=%b pulse=%b tready=%b, required all 0",
               grant_ch, busy, timeout_pulse, bus.s_axis_tready);
    end
    #2 rst = 1'b0;
    step();
    step();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_req: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_single();
    logic [4:0] e_busy = 5'b00111;
    logic [4:0] e_vld  = 5'b01110;
    logic [4:0] e_last = 5'b01000;
    logic [7:0] e_dat [5] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    bus.m_axis_tready = 1'b1;
    push(1, 8'h11, 1'b0);
    push(1, 8'h22, 1'b0);
    push(1, 8'h33, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (busy !== e_busy[i] || bus.m_axis_tvalid !== e_vld[i]) begin
        miscompares++;
        $display("FAIL single_ctl[%0d]: busy=%b vld=%b, required busy=%b vld=%b",
                 i, busy, bus.m_axis_tvalid, e_busy[i], e_vld[i]);
      end
      if (e_vld[i]) begin
        vectors++;
        if ({bus.m_axis_tid, bus.m_axis_tlast, bus.m_axis_tdata} !== {2'd1, e_last[i], e_dat[i]}) begin
          miscompares++;
          $display("FAIL single_beat[%0d]: tid=%0d last=%b data=%h, required tid=1 last=%b data=%h",
                   i, bus.m_axis_tid, bus.m_axis_tlast, bus.m_axis_tdata, e_last[i], e_dat[i]);
        end
      end
      if (i == 0) begin
        vectors++;
        if (grant_ch !== 2'd1) begin
          miscompares++;
          $display("FAIL single_grant: grant=%0d, required 1", grant_ch);
        end
      end
    end
    vectors++;
    if (n_out !== 3) begin
      miscompares++;
      $display("FAIL single_count: beats=%0d, required 3", n_out);
    end
  endtask

  task automatic test_fairness();
    logic [10:0] e;
    do_reset();
    bus.m_axis_tready = 1'b1;
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < NUM_CH; c++)
        for (int b = 0; b < 2; b++)
          push(c, 8'((c << 4) | (p << 1) | b), b[0]);
    for (int i = 0; i < 100 && n_out < 16; i++) step();
    vectors++;
    if (n_out !== 16) begin
      miscompares++;
      $display("FAIL fair_count: beats=%0d, required 16", n_out);
    end else begin
      for (int k = 0; k < 16; k++) begin
        int p, c, b;
        p = k / 8;
        c = (k / 2) % 4;
        b = k % 2;
        e = {2'(c), b[0], 8'((c << 4) | (p << 1) | b)};
        vectors++;
        if ({o_tid[k], o_last[k], o_data[k]} !== e) begin
          miscompares++;
          $display("FAIL fair_beat[%0d]: tid/last/data=%0d/%b/%h, required %0d/%b/%h",
                   k, o_tid[k], o_last[k], o_data[k], e[10:9], e[8], e[7:0]);
        end
        if (k > 0) begin
          vectors++;
          if (o_cyc[k] - o_cyc[k-1] !== (b == 0 ? 2 : 1)) begin
            miscompares++;
            $display("FAIL fair_gap[%0d]: gap=%0d, required %0d",
                     k, o_cyc[k] - o_cyc[k-1], (b == 0 ? 2 : 1));
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] pat = 4'b1001;
    int s;
    n_out = 0;
    for (int i = 1; i <= 8; i++) push(2, 8'(i), i == 8);
    s = 0;
    while (s < 100 && n_out < 8) begin
      bus.m_axis_tready = pat[s % 4];
      step();
      s++;
    end
    bus.m_axis_tready = 1'b1;
    vectors++;
    if (n_out !== 8) begin
      miscompares++;
      $display("FAIL bp_count: beats=%0d, required 8", n_out);
    end else begin
      for (int k = 0; k < 8; k++) begin
        vectors++;
        if ({o_tid[k], o_last[k], o_data[k]} !== {2'd2, k == 7, 8'(k + 1)}) begin
          miscompares++;
          $display("FAIL bp_beat[%0d]: tid/last/data=%0d/%b/%h, required 2/%b/%h",
                   k, o_tid[k], o_last[k], o_data[k], k == 7, 8'(k + 1));
        end
      end
    end
  endtask

  task automatic test_timeout();
    int pulses;
    do_reset();
    bus.m_axis_tready = 1'b1;
    push(0, 8'h55, 1'b0);
    push(3, 8'h99, 1'b1);
    for (int i = 0; i < 10 && !acc[0]; i++) step();
    vectors++;
    if (!acc[0]) begin
      miscompares++;
      $display("FAIL to_accept: ch0 beat not accepted within 10 cycles, required accept");
    end
    for (int k = 1; k <= 16; k++) begin
      step();
      vectors++;
      if (timeout_pulse !== (k == 16) || busy !== (k < 16)) begin
        miscompares++;
        $display("FAIL to_cycle[%0d]: pulse=%b busy=%b, required pulse=%b busy=%b",
                 k, timeout_pulse, busy, k == 16, k < 16);
      end
    end
    step();
    vectors++;
    if (grant_ch !== 2'd3 || busy !== 1'b1 || timeout_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL to_next_grant: grant=%0d busy=%b pulse=%b, required 3/1/0",
               grant_ch, busy, timeout_pulse);
    end
    for (int i = 0; i < 10 && n_out < 2; i++) step();
    vectors++;
    if (n_out !== 2 || {o_tid[0], o_last[0], o_data[0]} !== {2'd0, 1'b0, 8'h55} ||
        {o_tid[1], o_last[1], o_data[1]} !== {2'd3, 1'b1, 8'h99}) begin
      miscompares++;
      $display("FAIL to_beats: n=%0d b0=%0d/%b/%h b1=%0d/%b/%h, required 2 0/0/55 3/1/99",
               n_out, o_tid[0], o_last[0], o_data[0], o_tid[1], o_last[1], o_data[1]);
    end
    // Backpressure must freeze the inactivity counter.
    n_out  = 0;
    pulses = 0;
    bus.m_axis_tready = 1'b0;
    push(1, 8'h66, 1'b0);
    for (int i = 0; i < 30; i++) begin
      step();
      if (timeout_pulse) pulses++;
    end
    vectors++;
    if (pulses !== 0 || busy !== 1'b1 || bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== 8'h66) begin
      miscompares++;
      $display("FAIL stall_hold: pulses=%0d busy=%b vld=%b data=%h, required 0/1/1/66",
               pulses, busy, bus.m_axis_tvalid, bus.m_axis_tdata);
    end
    bus.m_axis_tready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      vectors++;
      if (timeout_pulse !== (k == 16)) begin
        miscompares++;
        $display("FAIL stall_to[%0d]: pulse=%b, required %b", k, timeout_pulse, k == 16);
      end
    end
    vectors++;
    if (n_out !== 1 || o_data[0] !== 8'h66 || o_tid[0] !== 2'd1) begin
      miscompares++;
      $display("FAIL stall_beat: n=%0d data=%h tid=%0d, required 1/66/1", n_out, o_data[0], o_tid[0]);
    end
  endtask

  task automatic test_reset_mid();
    bus.m_axis_tready = 1'b1;
    clear_queues();
    push(1, 8'hC1, 1'b0);
    push(1, 8'hC2, 1'b0);
    push(1, 8'hC3, 1'b1);
    for (int i = 0; i < 10 && !acc[1]; i++) step();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.m_axis_tvalid !== 1'b0 || bus.s_axis_tready !== '0 || busy !== 1'b0 || grant_ch !== '0) begin
      miscompares++;
      $display("FAIL rst_mid: vld=%b tready=%b busy=%b grant=%0d, required 0/0000/0/0",
               bus.m_axis_tvalid, bus.s_axis_tready, busy, grant_ch);
    end
    clear_queues();
    push(0, 8'hD0, 1'b1);
    push(1, 8'hE0, 1'b1);
    @(posedge clk);
    #2 rst = 1'b0;
    step();
    vectors++;
    if (grant_ch !== 2'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_first_grant: grant=%0d busy=%b, required 0/1", grant_ch, busy);
    end
    for (int i = 0; i < 20 && n_out < 2; i++) step();
    vectors++;
    if (n_out !== 2 || {o_tid[0], o_data[0]} !== {2'd0, 8'hD0} || {o_tid[1], o_data[1]} !== {2'd1, 8'hE0}) begin
      miscompares++;
      $display("FAIL rst_order: n=%0d b0=%0d/%h b1=%0d/%h, required 2 0/D0 1/E0",
               n_out, o_tid[0], o_data[0], o_tid[1], o_data[1]);
    end
  endtask

`ifdef UART_ARB_HDR_EN
  task automatic test_hdr();
    do_reset();
    bus.m_axis_tready = 1'b1;
    push(2, 8'h7E, 1'b1);
    for (int i = 0; i < 20 && n_out < 2; i++) step();
    vectors++;
    if (n_out !== 2 || {o_tid[0], o_last[0], o_data[0]} !== {2'd2, 1'b0, 8'hA2} ||
        {o_tid[1], o_last[1], o_data[1]} !== {2'd2, 1'b1, 8'h7E}) begin
      miscompares++;
      $display("FAIL hdr_beats: n=%0d b0=%0d/%b/%h b1=%0d/%b/%h, required 2 2/0/A2 2/1/7E",
               n_out, o_tid[0], o_last[0], o_data[0], o_tid[1], o_last[1], o_data[1]);
    end
  endtask
`endif

  initial begin
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tlast  = '0;
    bus.m_axis_tready = 1'b1;
    cyc   = 0;
    n_out = 0;
    acc   = '0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_timeout();
    test_reset_mid();
`ifdef UART_ARB_HDR_EN
    test_hdr();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares a single UART transmit path (the `uart` AXIS slave input) between NUM_CH independent AXIS byte-stream requesters.
- Round-robin arbitration at packet granularity: a grant is held from the first beat until the tlast beat is accepted.
- A registered output stage feeds the uart s_axis port.
- An inactivity timeout frees the path if a requester stalls mid-packet.

Parameters:
- NUM_CH, 4, number of requester channels (2..16).
- AXIS_WIDTH, 8, data width of every AXIS port.
- TIMEOUT_CYC, 1024, cycles of granted-channel tvalid-low mid-packet before forced release; 0 disables the timeout.
- CHW (localparam), $clog2(NUM_CH), channel index width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  NUM_CH*AXIS_WIDTH  per-channel data; channel i occupies bits [i*AXIS_WIDTH +: AXIS_WIDTH].
- s_axis_tvalid  in  NUM_CH  per-channel valid.
- s_axis_tlast  in  NUM_CH  per-channel end of packet.
- s_axis_tready  out  NUM_CH  per-channel ready; at most one bit high.
- m_axis_tdata  out  AXIS_WIDTH  registered output data, to uart s_axis_tdata.
- m_axis_tvalid  out  1  registered output valid.
- m_axis_tlast  out  1  registered output last.
- m_axis_tid  out  CHW  source channel of the current output beat.
- m_axis_tready  in  1  downstream ready.
- grant_ch  out  CHW  currently or last granted channel.
- busy  out  1  high while in any state other than IDLE.
- timeout_pulse  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset values: all outputs 0. last_grant=NUM_CH-1, so channel 0 wins first. State=IDLE, timeout counter=0.
- out_ready = !m_axis_tvalid || m_axis_tready. The output register loads only when out_ready.
- IDLE:
  - All s_axis_tready=0.
  - If any tvalid, select the first valid channel searching from last_grant+1 with wrap modulo NUM_CH.
  - Register the selection in grant_ch and go to PASS (HDR if the feature is enabled).
  - Arbitration costs exactly one cycle.
  - With no tvalid, stay in IDLE.
- PASS:
  - s_axis_tready[grant_ch]=out_ready; all other readies 0.
  - Accepted beat (tvalid&&tready): on the next edge m_axis_tdata/tlast take the beat, m_axis_tid=grant_ch, m_axis_tvalid=1.
  - Accepted beat with tlast: last_grant<=grant_ch, go to IDLE. This leaves one bubble cycle between packets.
- Output drain: if m_axis_tready and no load occurs, m_axis_tvalid<=0. Load and drain in the same cycle give back-to-back beats at full rate.
- Latency: input accept to m_axis_tvalid is 1 cycle.
- Timeout:
  - The counter increments each PASS cycle in which tvalid[grant_ch]=0.
  - It clears on any accepted beat and on leaving PASS.
  - When it reaches TIMEOUT_CYC-1 and increments: go to IDLE, last_grant<=grant_ch, timeout_pulse=1 for one cycle.
  - No tlast is synthesised; the already-registered output beat still drains normally.
- Stall: downstream backpressure (out_ready=0) never advances the timeout counter, even when tvalid is low.
- Simultaneous events: a tlast accept plus a timeout in the same cycle counts as a normal end; no pulse.
- Channel rules:
  - A channel dropping tvalid between packets loses nothing.
  - Non-granted channels are never accepted.
  - Single-beat packets (tvalid with tlast on the first beat) are legal.
- Reset mid-packet: immediate return to reset values. The in-flight output beat is discarded.

Optional Feature:
- Macro: UART_ARB_HDR_EN.
- Defined:
  - After IDLE, go to state HDR.
  - HDR: all s_axis_tready=0. When out_ready, load the output register with the header byte {4'hA, grant_ch zero-extended to AXIS_WIDTH-4}, tlast=0, tid=grant_ch, then go to PASS.
  - The timeout counter is inactive in HDR.
  - Each packet is therefore prefixed on the wire by one channel-tag byte.
- Undefined: no HDR state; IDLE goes directly to PASS. Header logic is absent from synthesis.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants ST_IDLE=0, ST_HDR=1, ST_PASS=2;
  - HDR_TAG=4'hA;
  - CHW derivation function.
- One natural sub-module, rr_arbiter: NUM_CH request vector plus last_grant in, one-hot grant plus encoded index out. Purely combinational, reusable elsewhere in the design.

Test Plan:
- Single channel: ch1 sends 3 bytes 0x11,0x22,0x33 (tlast on 0x33), m_axis_tready=1 -> output beats appear 1 cycle after each accept with tid=1, tlast only on 0x33, then busy=0.
- Fairness: all 4 channels continuously send 2-byte packets -> grant order 0,1,2,3,0, one bubble cycle between packets, no interleaving.
- Backpressure: ch2 streams 0x01..0x08 while m_axis_tready toggles 1,0,0,1 -> every byte appears exactly once in order, s_axis_tready[2] tracks out_ready, no beat dropped.
- Timeout: TIMEOUT_CYC=16; ch0 sends 0x55 without tlast then tvalid=0 -> timeout_pulse on cycle 16 after the accept, state IDLE; ch3 is then granted next.
- Reset mid-packet: assert rst during ch1 beat 2 -> m_axis_tvalid=0 and all readies=0 immediately; after release ch0 is granted first.
- UART_ARB_HDR_EN defined: ch2 sends 0x7E with tlast -> output 0xA2 (tlast=0) then 0x7E (tlast=1), both with tid=2.
